dac_spi_tx: RTL and testbench
=============================

DAC_SPI_TX -- requirements
Module: dac_spi_tx

Interface
REQ-001 Parameter CLK_DIV, default 4, SCLK half-period in clk cycles; legal values are integers >= 2.
REQ-002 Parameter GAP, default 2, minimum number of clk cycles oc_cs_n stays high between frames; legal values >= 1.
REQ-003 clk  in  1  sole clock; all logic updates on its rising edge.
REQ-004 ic_rst_n  in  1  reset, synchronous, active-low.
REQ-005 id_data  in  16  sample from the modulator output stage, S[16,15].
REQ-006 ic_val_data  in  1  one-cycle qualifier for id_data.
REQ-007 od_sclk  out  1  SPI serial clock to the DAC, idle low (mode 0).
REQ-008 od_mosi  out  1  SPI serial data, MSB first.
REQ-009 oc_cs_n  out  1  DAC chip select, active-low.
REQ-010 oc_busy  out  1  high while a frame is in progress or the buffer is non-empty.
REQ-011 oc_ovf  out  1  sticky flag: at least one sample was dropped since reset.

Function
REQ-012 All outputs SHALL be driven directly from registers, with no combinational path from inputs to outputs.
REQ-013 Input samples SHALL enter a 2-entry FIFO; a sample SHALL be written when ic_val_data=1 and either the FIFO is not full or a pop occurs in the same cycle.
REQ-014 When ic_val_data=1 while the FIFO is full and no pop occurs, the sample SHALL be discarded and oc_ovf set to 1 on the next cycle; FIFO contents SHALL remain unchanged.
REQ-015 On write, id_data SHALL be stored converted to offset binary: {~id_data[15], id_data[14:0]}; 0x8000->0x0000, 0x0000->0x8000, 0x7FFF->0xFFFF.
REQ-016 FSM states SHALL be IDLE, SHIFT, and END.
REQ-017 In IDLE with the FIFO non-empty at cycle T, the head entry SHALL be popped into a 16-bit shift register and the FSM SHALL enter SHIFT; at T+1, oc_cs_n=0, od_sclk=0, and od_mosi=bit15.
REQ-018 In SHIFT, each bit SHALL last 2*CLK_DIV cycles: CLK_DIV cycles with od_sclk=0, then CLK_DIV cycles with od_sclk=1.
REQ-019 od_mosi SHALL change only when od_sclk goes high-to-low, or at frame start, and SHALL be stable across every rising edge of od_sclk.
REQ-020 The FSM SHALL count exactly 16 bits in SHIFT, MSB first; after the high phase of bit 0, od_sclk=0, oc_cs_n=1, od_mosi=0, and the FSM SHALL enter END, at cycle T+1+32*CLK_DIV.
REQ-021 The FSM SHALL stay in END for GAP cycles, then return to IDLE, where it may pop in that same cycle.
REQ-022 Back-to-back frame period SHALL be 1+32*CLK_DIV+GAP cycles (131 at defaults).
REQ-023 oc_busy SHALL be 1 whenever FSM != IDLE or the FIFO is non-empty, evaluated on registered state.
REQ-024 A simultaneous write and pop on a full FIFO SHALL keep occupancy at 2 and preserve order.
REQ-025 The write and read pointers SHALL wrap modulo 2; FIFO order SHALL be strictly first-in first-out.

Reset
REQ-026 While ic_rst_n=0 at a clock edge, on the following cycle: od_sclk=0, od_mosi=0, oc_cs_n=1, oc_busy=0, oc_ovf=0, FIFO empty, FSM=IDLE, shift register and bit counter cleared.
REQ-027 Reset asserted mid-frame SHALL abort the frame immediately with no further od_sclk edges; samples presented in the same cycle as reset SHALL be discarded.
REQ-028 ic_val_data SHALL be accepted from the first cycle after ic_rst_n returns to 1.

Verification
REQ-029 Single sample: id_data=0x4000 with val at cycle 0 -> oc_cs_n low for 128 cycles, 16 rising od_sclk edges, od_mosi shifts out 0xC000 MSB first, oc_busy=0 after END.
REQ-030 Code mapping: sequence 0x8000, 0x0000, 0x7FFF -> frames 0x0000, 0x8000, 0xFFFF in order, each frame start 131 cycles apart, oc_ovf=0.
REQ-031 Overflow: 4 samples on consecutive cycles -> first 3 transmitted (1 in shift, 2 in FIFO), 4th dropped, oc_ovf=1 from cycle 4 and held until reset.
REQ-032 Full-FIFO write coinciding with a pop -> sample accepted, no ovf, all frames in order.
REQ-033 Reset pulse at bit 7 of a frame -> next cycle oc_cs_n=1, od_sclk=0, oc_busy=0, oc_ovf=0; a new sample afterwards transmits normally.
REQ-034 CLK_DIV=2, GAP=1 -> frame period 66 cycles, SCLK period 4 cycles, protocol checker reports no mode-0 setup violations.

Source files
------------

// File: rtl/dac_spi_tx.sv
// SPI mode-0 transmitter for a 16-bit DAC. Samples arrive in two's complement, are stored
// in offset binary in a 2-entry FIFO, and are shifted out MSB first, one frame per sample.
module dac_spi_tx #(
    parameter int unsigned CLK_DIV = 4,  // SCLK half-period in clk cycles (>= 2)
    parameter int unsigned GAP     = 2   // minimum clk cycles with chip select high (>= 1)
) (
    input  logic        clk,
    input  logic        ic_rst_n,
    input  logic [15:0] id_data,
    input  logic        ic_val_data,
    output logic        od_sclk,
    output logic        od_mosi,
    output logic        oc_cs_n,
    output logic        oc_busy,
    output logic        oc_ovf
);

    localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned GapW = $clog2(GAP + 1);
    localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);
    localparam logic [GapW-1:0] GapLast = GapW'(GAP - 1);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StEnd
    } state_e;

    state_e          state_q;
    logic [15:0]     mem_q [2];
    logic            wr_ptr_q;
    logic            rd_ptr_q;
    logic [1:0]      cnt_q;
    logic [1:0]      cnt_d;
    logic            push;
    logic            pop;
    logic            drop;
    logic            next_idle;
    logic [15:0]     sh_q;      // bits still to send, next bit in [15]
    logic [3:0]      bit_q;
    logic [DivW-1:0] div_q;
    logic [GapW-1:0] gap_q;
    logic            sclk_q;
    logic            mosi_q;
    logic            cs_n_q;
    logic            busy_q;
    logic            ovf_q;

    // FIFO handshake and whether the FSM is idle after this edge
    always_comb begin
        pop   = (state_q == StIdle) && (cnt_q != 2'd0);
        // a full FIFO still accepts when the head leaves in the same cycle
        push  = ic_val_data && ((cnt_q != 2'd2) || pop);
        drop  = ic_val_data && !push;
        cnt_d = cnt_q;
        if (push && !pop) begin
            cnt_d = cnt_q + 2'd1;
        end else if (pop && !push) begin
            cnt_d = cnt_q - 2'd1;
        end
        next_idle = ((state_q == StIdle) && !pop) ||
                    ((state_q == StEnd) && (gap_q == GapLast));
    end

    // FIFO storage, pointers, occupancy and sticky overflow flag
    always_ff @(posedge clk) begin
        if (!ic_rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
            ovf_q    <= 1'b0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= {~id_data[15], id_data[14:0]};
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            cnt_q <= cnt_d;
            if (drop) begin
                ovf_q <= 1'b1;
            end
        end
    end

    // Frame FSM: all SPI pins and busy are registered here
    always_ff @(posedge clk) begin
        if (!ic_rst_n) begin
            state_q <= StIdle;
            sh_q    <= '0;
            bit_q   <= '0;
            div_q   <= '0;
            gap_q   <= '0;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            cs_n_q  <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            busy_q <= !next_idle || (cnt_d != 2'd0);
            case (state_q)
                StIdle: begin
                    if (pop) begin
                        mosi_q  <= mem_q[rd_ptr_q][15];
                        sh_q    <= {mem_q[rd_ptr_q][14:0], 1'b0};
                        cs_n_q  <= 1'b0;
                        sclk_q  <= 1'b0;
                        div_q   <= '0;
                        bit_q   <= '0;
                        state_q <= StShift;
                    end
                end
                StShift: begin
                    if (div_q == DivLast) begin
                        div_q <= '0;
                        if (!sclk_q) begin
                            sclk_q <= 1'b1;
                        end else begin
                            // end of a bit: SCLK falls and MOSI moves on together
                            sclk_q <= 1'b0;
                            if (bit_q == 4'd15) begin
                                cs_n_q  <= 1'b1;
                                mosi_q  <= 1'b0;
                                gap_q   <= '0;
                                state_q <= StEnd;
                            end else begin
                                bit_q  <= bit_q + 4'd1;
                                mosi_q <= sh_q[15];
                                sh_q   <= {sh_q[14:0], 1'b0};
                            end
                        end
                    end else begin
                        div_q <= div_q + DivW'(1);
                    end
                end
                StEnd: begin
                    if (gap_q == GapLast) begin
                        state_q <= StIdle;
                    end else begin
                        gap_q <= gap_q + GapW'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign od_sclk = sclk_q;
    assign od_mosi = mosi_q;
    assign oc_cs_n = cs_n_q;
    assign oc_busy = busy_q;
    assign oc_ovf  = ovf_q;

endmodule

// File: tb/tb_dac_spi_tx.sv
// Self-checking bench for dac_spi_tx: one instance at default timing, one at the fastest
// legal timing. A per-instance frame monitor decodes SPI frames and compares them with
// a scoreboard queue filled as samples are driven.
module tb_dac_spi_tx;

    localparam int CD      = 4;
    localparam int GP      = 2;
    localparam int PERIOD  = 1 + 32 * CD + GP;
    localparam int CD2     = 2;
    localparam int GP2     = 1;
    localparam int PERIOD2 = 1 + 32 * CD2 + GP2;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        val   = 1'b0;
    logic        val2  = 1'b0;
    logic [15:0] data  = 16'h0;
    logic [15:0] data2 = 16'h0;
    logic        sclk, mosi, cs_n, busy, ovf;
    logic        sclk2, mosi2, cs_n2, busy2, ovf2;

    always #5 clk = ~clk;

    dac_spi_tx #(.CLK_DIV(CD), .GAP(GP)) u_dut (
        .clk        (clk),
        .ic_rst_n   (rst_n),
        .id_data    (data),
        .ic_val_data(val),
        .od_sclk    (sclk),
        .od_mosi    (mosi),
        .oc_cs_n    (cs_n),
        .oc_busy    (busy),
        .oc_ovf     (ovf)
    );

    dac_spi_tx #(.CLK_DIV(CD2), .GAP(GP2)) u_dut2 (
        .clk        (clk),
        .ic_rst_n   (rst_n),
        .id_data    (data2),
        .ic_val_data(val2),
        .od_sclk    (sclk2),
        .od_mosi    (mosi2),
        .oc_cs_n    (cs_n2),
        .oc_busy    (busy2),
        .oc_ovf     (ovf2)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- frame monitor / scoreboard ----------------
    logic        prev_cs   [2] = '{1'b1, 1'b1};
    logic        prev_sclk [2] = '{1'b0, 1'b0};
    logic        prev_mosi [2] = '{1'b0, 1'b0};
    int          bits      [2];
    int          len       [2];
    int          last_rise [2];
    int          viol      [2];
    logic [15:0] shr       [2];
    int          starts0[$];
    int          starts1[$];
    logic [15:0] exp0[$];
    logic [15:0] exp1[$];
    bit          abort = 1'b0;

    task automatic mon_step(input int k, input logic s, input logic m, input logic c);
        int          dcd;
        logic [15:0] e;
        dcd = (k == 0) ? CD : CD2;
        if (c === 1'b0) begin
            if (prev_cs[k] === 1'b1) begin
                bits[k]      = 0;
                len[k]       = 0;
                shr[k]       = '0;
                last_rise[k] = -1;
                if (k == 0) starts0.push_back(cyc);
                else        starts1.push_back(cyc);
            end else if (m !== prev_mosi[k] && !(prev_sclk[k] === 1'b1 && s === 1'b0)) begin
                viol[k]++;  // MOSI moved other than on an SCLK falling edge
            end
            len[k]++;
            if (prev_sclk[k] === 1'b0 && s === 1'b1) begin
                shr[k] = {shr[k][14:0], m};
                bits[k]++;
                if (last_rise[k] >= 0 && cyc - last_rise[k] != 2 * dcd) viol[k]++;
                last_rise[k] = cyc;
            end
        end else if (c === 1'b1) begin
            if (s !== 1'b0) viol[k]++;
            if (prev_cs[k] === 1'b0) begin
                if (k == 0 && abort) begin
                    abort = 1'b0;
                    check("abort_bits", 32'(bits[k]), 32'd8);
                end else begin
                    check($sformatf("frame_len[%0d]", k), 32'(len[k]), 32'(32 * dcd));
                    check($sformatf("frame_bits[%0d]", k), 32'(bits[k]), 32'd16);
                    check($sformatf("frame_end_mosi[%0d]", k), 32'(m), 32'd0);
                    if (k == 0) begin
                        check("frame_expected0", 32'(exp0.size() != 0), 32'd1);
                        if (exp0.size() != 0) begin
                            e = exp0.pop_front();
                            check("frame_data0", 32'(shr[k]), 32'(e));
                        end
                    end else begin
                        check("frame_expected1", 32'(exp1.size() != 0), 32'd1);
                        if (exp1.size() != 0) begin
                            e = exp1.pop_front();
                            check("frame_data1", 32'(shr[k]), 32'(e));
                        end
                    end
                end
            end
        end
        prev_cs[k]   = c;
        prev_sclk[k] = s;
        prev_mosi[k] = m;
    endtask

    always @(negedge clk) begin
        mon_step(0, sclk, mosi, cs_n);
        mon_step(1, sclk2, mosi2, cs_n2);
    end

    // ---------------- stimulus helpers ----------------
    // e returns the cyc value right after the edge that samples the input
    task automatic put(input int k, input logic [15:0] d, output int e);
        @(negedge clk);
        if (k == 0) begin
            val  = 1'b1;
            data = d;
        end else begin
            val2  = 1'b1;
            data2 = d;
        end
        e = cyc + 1;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(negedge clk);
            val  = 1'b0;
            val2 = 1'b0;
        end
    endtask

    task automatic wait_idle(input int k, input string name);
        int n;
        n = 0;
        while (!((k == 0) ? (busy === 1'b0 && cs_n === 1'b1)
                          : (busy2 === 1'b0 && cs_n2 === 1'b1)) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(n >= 5000), 32'd0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        val   = 1'b0;
        val2  = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [15:0] din;
        logic [15:0] frame;
    } vec_t;

    initial begin
        vec_t vecs [6];
        int   e;
        int   ea;
        int   n;

        vecs[0] = '{16'h8000, 16'h0000};
        vecs[1] = '{16'h0000, 16'h8000};
        vecs[2] = '{16'h7FFF, 16'hFFFF};
        vecs[3] = '{16'h4000, 16'hC000};
        vecs[4] = '{16'hFFFF, 16'h7FFF};
        vecs[5] = '{16'h1234, 16'h9234};

        // reset values
        repeat (3) @(negedge clk);
        check("rst_cs_n", 32'(cs_n), 32'd1);
        check("rst_sclk", 32'(sclk), 32'd0);
        check("rst_mosi", 32'(mosi), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_cs_n2", 32'(cs_n2), 32'd1);
        check("rst_busy2", 32'(busy2), 32'd0);
        rst_n = 1'b1;
        idle_cycles(3);

        // single sample: latency, frame, busy drop
        starts0.delete();
        put(0, 16'h4000, e);
        exp0.push_back(16'hC000);
        idle_cycles(1);
        check("single_busy", 32'(busy), 32'd1);
        wait_idle(0, "single_timeout");
        check("single_busy_fall", 32'(cyc - e), 32'(PERIOD));
        check("single_start", 32'((starts0.size() == 1) ? starts0[0] - e : -1), 32'd1);
        idle_cycles(5);

        // code mapping, bursts of three back-to-back
        for (int b = 0; b < 2; b++) begin
            starts0.delete();
            for (int i = 0; i < 3; i++) begin
                put(0, vecs[3 * b + i].din, e);
                exp0.push_back(vecs[3 * b + i].frame);
            end
            idle_cycles(1);
            wait_idle(0, "table_timeout");
            check("table_frames", 32'(starts0.size()), 32'd3);
            for (int i = 1; i < starts0.size(); i++) begin
                check("table_period", 32'(starts0[i] - starts0[i - 1]), 32'(PERIOD));
            end
            check("table_ovf", 32'(ovf), 32'd0);
            idle_cycles(3);
        end

        // overflow: fourth consecutive sample is dropped
        put(0, 16'h0001, e);
        put(0, 16'hFFFE, e);
        put(0, 16'h8001, e);
        put(0, 16'h5555, e);
        check("ovf_before_drop", 32'(ovf), 32'd0);
        idle_cycles(1);
        check("ovf_after_drop", 32'(ovf), 32'd1);
        exp0.push_back(16'h8001);
        exp0.push_back(16'h7FFE);
        exp0.push_back(16'h0001);
        wait_idle(0, "ovf_timeout");
        check("ovf_sticky", 32'(ovf), 32'd1);
        check("ovf_queue_empty", 32'(exp0.size()), 32'd0);

        // reset clears the sticky flag
        apply_reset();
        check("ovf_cleared", 32'(ovf), 32'd0);
        idle_cycles(2);

        // write to a full FIFO in the same cycle as a pop
        put(0, 16'h0A0A, ea);
        put(0, 16'hB0B0, e);
        put(0, 16'h0C0C, e);
        idle_cycles(1);
        exp0.push_back(16'h8A0A);
        exp0.push_back(16'h30B0);
        exp0.push_back(16'h8C0C);
        while (cyc < ea + PERIOD) @(negedge clk);
        val  = 1'b1;
        data = 16'hD0D0;
        exp0.push_back(16'h50D0);
        idle_cycles(1);
        check("fullpop_ovf", 32'(ovf), 32'd0);
        wait_idle(0, "fullpop_timeout");
        check("fullpop_ovf_end", 32'(ovf), 32'd0);
        check("fullpop_queue_empty", 32'(exp0.size()), 32'd0);
        idle_cycles(3);

        // reset at bit 7 of a frame; sample in the reset cycle discarded, next accepted
        put(0, 16'h2BCD, e);
        idle_cycles(1);
        n = 0;
        while (bits[0] != 8 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("abort_reach_bit7", 32'(n >= 2000), 32'd0);
        @(negedge clk);
        abort = 1'b1;
        rst_n = 1'b0;
        val   = 1'b1;
        data  = 16'h1111;
        @(negedge clk);
        rst_n = 1'b1;
        data  = 16'h6789;
        exp0.push_back(16'hE789);
        check("abort_cs_n", 32'(cs_n), 32'd1);
        check("abort_sclk", 32'(sclk), 32'd0);
        check("abort_mosi", 32'(mosi), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_ovf", 32'(ovf), 32'd0);
        idle_cycles(1);
        check("post_rst_accept", 32'(busy), 32'd1);
        wait_idle(0, "post_rst_timeout");
        check("post_rst_queue_empty", 32'(exp0.size()), 32'd0);
        check("abort_handled", 32'(abort), 32'd0);

        // fastest timing instance
        starts1.delete();
        put(1, 16'h0F0F, e);
        put(1, 16'hC3A5, e);
        idle_cycles(1);
        exp1.push_back(16'h8F0F);
        exp1.push_back(16'h43A5);
        wait_idle(1, "fast_timeout");
        check("fast_frames", 32'(starts1.size()), 32'd2);
        if (starts1.size() == 2) begin
            check("fast_period", 32'(starts1[1] - starts1[0]), 32'(PERIOD2));
        end
        check("fast_queue_empty", 32'(exp1.size()), 32'd0);
        check("fast_ovf", 32'(ovf2), 32'd0);

        idle_cycles(4);
        check("protocol_viol0", 32'(viol[0]), 32'd0);
        check("protocol_viol1", 32'(viol[1]), 32'd0);
        check("queue0_drained", 32'(exp0.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
